// File: rtl/counter_scheduler_pkg.sv
// Counter scheduler shared types.
// FSM state encoding and index-width helper.
package counter_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_scheduler_if.sv
// Requester / shared-counter bundle of the counter scheduler.
// master: parent side, slave: scheduler side.
interface counter_scheduler_if #(
    parameter int N     = 4,
    parameter int WIDTH = 4
);
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] len;
    logic               tick;
    logic [N-1:0]       grant;
    logic [N-1:0]       done;
    logic               busy;
    logic               cnt_load;
    logic [WIDTH-1:0]   cnt_d;
    logic               cnt_enable;
    logic [WIDTH-1:0]   cnt_q;

    modport master (
        output req, len, tick, cnt_q,
        input  grant, done, busy, cnt_load, cnt_d, cnt_enable
    );

    modport slave (
        input  req, len, tick, cnt_q,
        output grant, done, busy, cnt_load, cnt_d, cnt_enable
    );
endinterface

// File: rtl/counter_scheduler_rrpick.sv
// Round-robin pick: first set request at or above ptr, wrapping.
// Purely combinational.
module counter_scheduler_rrpick
    import counter_scheduler_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                idx   = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/counter_scheduler.sv
// Arbitrates one shared modulo-MAX counter among N requesters.
// Owner runs L ticks by preloading MAX-L and waiting for the wrap.
module counter_scheduler
    import counter_scheduler_pkg::*;
#(
    parameter int N     = 4,
    parameter int MAX   = 16,
    parameter int WIDTH = $clog2(MAX)
) (
    input  logic clock,
    input  logic reset_n,
    counter_scheduler_if.slave bus
);

    localparam int               IW   = idx_w(N);
    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MAX - 1);
    localparam logic [WIDTH:0]   MAXW = (WIDTH + 1)'(MAX);

    state_t           state_q;
    logic [IW-1:0]    ptr_q;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    ptr_nxt;
    logic [WIDTH-1:0] l_q;
    logic [N-1:0]     grant_q;
    logic [N-1:0]     done_q;
    logic             pick_valid;
    logic             abort;
    logic             wrap;

    counter_scheduler_rrpick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Owner withdrawing its request while holding the counter.
    assign abort = (state_q == LOAD || state_q == RUN)
                 && !bus.req[idx_q];

    assign wrap    = bus.tick && (bus.cnt_q == TOP);
    assign ptr_nxt = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.cnt_load   = (state_q == LOAD) && !abort
                          && (l_q != '0);
    assign bus.cnt_d      = WIDTH'(MAXW - {1'b0, l_q});
    assign bus.cnt_enable = (state_q == RUN) && !abort
                          && bus.tick;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            l_q     <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            done_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        idx_q   <= pick_idx;
                        l_q     <= bus.len[int'(pick_idx)*WIDTH +: WIDTH];
                        grant_q <= N'(1) << pick_idx;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_nxt;
                        state_q <= IDLE;
                    end else if (l_q == '0) begin
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        grant_q <= '0;
                        ptr_q   <= ptr_nxt;
                        state_q <= IDLE;
                    end else if (wrap) begin
                        done_q  <= grant_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    grant_q <= '0;
                    ptr_q   <= ptr_nxt;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
